// File: rtl/box_position_ctrl.sv
// rtl/box_position_ctrl.sv - debounced push-button control of a clamped box offset, stepped once per frame
module box_position_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP            = 5,
    parameter int REPEAT_DELAY    = 20,
    parameter int X_MAX           = 480,
    parameter int Y_MAX           = 320,
    parameter int X_INIT          = 0,
    parameter int Y_INIT          = 0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       btn_right_n,
    input  logic       btn_left_n,
    input  logic       btn_down_n,
    input  logic       btn_up_n,
    input  logic       vs_n,
    output logic [9:0] x_offset,
    output logic [9:0] y_offset,
    output logic       pos_valid,
    output logic [3:0] btn_state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int FC_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(REPEAT_DELAY);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    logic [3:0]      sync_q1;
    logic [3:0]      sync_q2;
    logic [DB_W-1:0] db_cnt [4];
    logic            vs_d;
    logic            tick;
    logic            held;
    logic [1:0]      state;
    logic [FC_W-1:0] frame_cnt;
    logic            do_move;

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] nx_s;
    logic signed [10:0] ny_s;
    logic [9:0]         nx;
    logic [9:0]         ny;

    // Buttons ordered {up, down, left, right}; synchronizer idles at released (1).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sync_q1 <= 4'hF;
            sync_q2 <= 4'hF;
        end else begin
            sync_q1 <= {btn_up_n, btn_down_n, btn_left_n, btn_right_n};
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            btn_state <= 4'b0000;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (~sync_q2[i] != btn_state[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        btn_state[i] <= ~btn_state[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign tick = vs_d & ~vs_n;
    assign held = |btn_state;

    always_comb begin
        dx = '0;
        dy = '0;
        if (btn_state[0] & ~btn_state[1]) dx = STEP_S;
        else if (btn_state[1] & ~btn_state[0]) dx = -STEP_S;
        if (btn_state[2] & ~btn_state[3]) dy = STEP_S;
        else if (btn_state[3] & ~btn_state[2]) dy = -STEP_S;

        nx_s = $signed({1'b0, x_offset}) + dx;
        ny_s = $signed({1'b0, y_offset}) + dy;

        nx = nx_s[9:0];
        if (nx_s < 0) nx = '0;
        else if (nx_s > X_MAX_S) nx = 10'(X_MAX);
        ny = ny_s[9:0];
        if (ny_s < 0) ny = '0;
        else if (ny_s > Y_MAX_S) ny = 10'(Y_MAX);

        do_move = 1'b0;
        if (held && tick) begin
            case (state)
                IDLE:    do_move = 1'b1;
                DELAY:   do_move = (frame_cnt <= FC_W'(1));
                REPEAT:  do_move = 1'b1;
                default: do_move = 1'b0;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vs_d      <= 1'b1;
            state     <= IDLE;
            frame_cnt <= '0;
            x_offset  <= 10'(X_INIT);
            y_offset  <= 10'(Y_INIT);
            pos_valid <= 1'b0;
        end else begin
            vs_d      <= vs_n;
            pos_valid <= 1'b0;
            if (!held) begin
                state     <= IDLE;
                frame_cnt <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        state     <= DELAY;
                        frame_cnt <= FC_LOAD;
                    end
                    DELAY: begin
                        if (frame_cnt <= FC_W'(1)) begin
                            state     <= REPEAT;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt - FC_W'(1);
                        end
                    end
                    REPEAT:  state <= REPEAT;
                    default: state <= IDLE;
                endcase
            end
            // A move that clamps to the current position is not reported.
            if (do_move && ((nx != x_offset) || (ny != y_offset))) begin
                x_offset  <= nx;
                y_offset  <= ny;
                pos_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_box_position_ctrl.sv
// tb/tb_box_position_ctrl.sv - randomized and directed self-checking bench for box_position_ctrl
module tb_box_position_ctrl;

    localparam int D    = 4;
    localparam int RD   = 3;
    localparam int STEP = 5;
    localparam int XM   = 20;
    localparam int YM   = 20;
    localparam int XI   = 10;
    localparam int YI   = 10;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_right_n = 1'b1;
    logic       btn_left_n = 1'b1;
    logic       btn_down_n = 1'b1;
    logic       btn_up_n = 1'b1;
    logic       vs_n = 1'b1;
    logic [9:0] x_offset;
    logic [9:0] y_offset;
    logic       pos_valid;
    logic [3:0] btn_state;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tick_count = 0;
    int pv_count = 0;
    bit started = 0;

    // Reference model state
    logic [3:0] m_h1, m_h2;
    int         m_run [4];
    logic [3:0] m_btn;
    int         m_x, m_y;
    bit         m_vsprev;
    int         m_held_ticks;
    bit         m_pv;

    box_position_ctrl #(
        .DEBOUNCE_CYCLES(D), .STEP(STEP), .REPEAT_DELAY(RD),
        .X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI)
    ) dut (
        .vga_clk(vga_clk), .reset(reset),
        .btn_right_n(btn_right_n), .btn_left_n(btn_left_n),
        .btn_down_n(btn_down_n), .btn_up_n(btn_up_n),
        .vs_n(vs_n),
        .x_offset(x_offset), .y_offset(y_offset),
        .pos_valid(pos_valid), .btn_state(btn_state)
    );

    initial forever #5 vga_clk = ~vga_clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Frame sync: vs_n low for 2 cycles every 50.
    initial forever begin
        @(negedge vga_clk);
        cyc++;
        vs_n = ((cyc % 50) < 2) ? 1'b0 : 1'b1;
        if ((cyc % 50) == 0) tick_count++;
    end

    // Behavioural model: moves on held-tick #1 and #(RD+1) onward; buttons accepted after D stable cycles.
    initial forever begin
        @(posedge vga_clk);
        if (reset) begin
            m_h1 = 4'hF; m_h2 = 4'hF;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_btn = 4'b0; m_x = XI; m_y = YI; m_vsprev = 1;
            m_held_ticks = 0; m_pv = 0;
            started = 1;
        end else begin
            bit tk;
            int dxm, dym, nxm, nym;
            tk = m_vsprev && !vs_n;
            m_pv = 0;
            if (m_btn == 4'b0) m_held_ticks = 0;
            else if (tk) begin
                m_held_ticks++;
                if (m_held_ticks == 1 || m_held_ticks > RD) begin
                    dxm = (m_btn[0] && !m_btn[1]) ? STEP : (m_btn[1] && !m_btn[0]) ? -STEP : 0;
                    dym = (m_btn[2] && !m_btn[3]) ? STEP : (m_btn[3] && !m_btn[2]) ? -STEP : 0;
                    nxm = clampi(m_x + dxm, XM);
                    nym = clampi(m_y + dym, YM);
                    if (nxm != m_x || nym != m_y) begin
                        m_x = nxm; m_y = nym; m_pv = 1;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!m_h2[i] != m_btn[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_btn[i] = !m_btn[i];
                        m_run[i] = 0;
                    end
                end else m_run[i] = 0;
            end
            m_h2 = m_h1;
            m_h1 = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};
            m_vsprev = vs_n;
        end
    end

    initial forever begin
        @(negedge vga_clk);
        if (started) begin
            check("x_model", int'(x_offset), m_x);
            check("y_model", int'(y_offset), m_y);
            check("pv_model", int'(pos_valid), int'(m_pv));
            check("btn_model", int'(btn_state), int'(m_btn));
            if (pos_valid) pv_count++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
        #1;
    endtask

    task automatic wait_tick();
        int t0 = tick_count;
        int k = 0;
        while (tick_count == t0 && k < 200) begin
            step(1);
            k++;
        end
        if (k >= 200) check("tick_timeout", 0, 1);
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    int pv0;
    int seq [6];
    int exp_down [6] = '{15, 15, 15, 20, 20, 20};
    int exp_left [6] = '{5, 5, 5, 0, 0, 0};

    initial begin
        step(2);
        reset = 1'b0;
        check("rst_x", int'(x_offset), 10);
        check("rst_y", int'(y_offset), 10);
        check("rst_pv", int'(pos_valid), 0);
        check("rst_btn", int'(btn_state), 0);

        // Short glitch must never be accepted
        pv0 = pv_count;
        btn_right_n = 1'b0; step(3); btn_right_n = 1'b1;
        step(8);
        check("glitch_btn", int'(btn_state), 0);
        check("glitch_pv", pv_count - pv0, 0);

        // Single press
        wait_tick();
        btn_right_n = 1'b0;
        step(6);
        check("press_latency_btn", int'(btn_state), 1);
        wait_tick();
        check("press_x", int'(x_offset), 15);
        check("press_pv", int'(pos_valid), 1);
        step(1);
        check("press_pv_width", int'(pos_valid), 0);
        btn_right_n = 1'b1;
        step(10);
        check("release_btn", int'(btn_state), 0);
        pv0 = pv_count;
        wait_tick(); wait_tick();
        check("release_nomove", pv_count - pv0, 0);
        check("release_x", int'(x_offset), 15);

        // Auto-repeat with high clamp
        do_reset();
        wait_tick();
        btn_down_n = 1'b0;
        step(8);
        pv0 = pv_count;
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            seq[i] = int'(y_offset);
        end
        for (int i = 0; i < 6; i++) check($sformatf("repeat_y%0d", i), seq[i], exp_down[i]);
        check("repeat_pv_count", pv_count - pv0, 2);
        btn_down_n = 1'b1;
        step(10);

        // Low clamp
        do_reset();
        wait_tick();
        btn_left_n = 1'b0;
        step(8);
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            seq[i] = int'(x_offset);
        end
        for (int i = 0; i < 6; i++) check($sformatf("clamp_x%0d", i), seq[i], exp_left[i]);
        btn_left_n = 1'b1;
        step(10);

        // Opposing pair plus up
        do_reset();
        wait_tick();
        btn_left_n = 1'b0; btn_right_n = 1'b0; btn_up_n = 1'b0;
        step(8);
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            check($sformatf("opp_x%0d", i), int'(x_offset), 10);
            check($sformatf("opp_y%0d", i), int'(y_offset), exp_left[i]);
        end
        btn_left_n = 1'b1; btn_right_n = 1'b1; btn_up_n = 1'b1;
        step(10);

        // Reset mid-REPEAT with button still held
        do_reset();
        wait_tick();
        btn_down_n = 1'b0;
        step(8);
        for (int i = 0; i < 5; i++) wait_tick();
        check("pre_rst_y", int'(y_offset), 20);
        do_reset();
        check("midrst_x", int'(x_offset), 10);
        check("midrst_y", int'(y_offset), 10);
        check("midrst_btn", int'(btn_state), 0);
        step(3);
        check("midrst_rebounce_btn", int'(btn_state), 0);
        check("midrst_hold_y", int'(y_offset), 10);
        wait_tick();
        check("midrst_first_move_y", int'(y_offset), 15);
        btn_down_n = 1'b1;
        step(10);

        // Randomized phase against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) btn_right_n = ~btn_right_n;
            if ($urandom_range(0, 15) == 0) btn_left_n  = ~btn_left_n;
            if ($urandom_range(0, 15) == 0) btn_down_n  = ~btn_down_n;
            if ($urandom_range(0, 15) == 0) btn_up_n    = ~btn_up_n;
            if ($urandom_range(0, 3) == 0) begin
                btn_right_n = 1'b1; btn_left_n = 1'b1; btn_down_n = 1'b1; btn_up_n = 1'b1;
                if ($urandom_range(0, 1) == 0) btn_left_n = 1'b0; else btn_right_n = 1'b0;
                if ($urandom_range(0, 1) == 0) btn_up_n = 1'b0; else btn_down_n = 1'b0;
                step($urandom_range(10, 200));
            end
            reset = ($urandom_range(0, 999) == 0);
            step(1);
        end
        reset = 1'b0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
